// File: rtl/fb_read_arbiter_pkg.sv
// Shared types and helpers for the frame buffer read arbiter.
// Holds the FSM state encoding, requester indices and the round-robin owner pick.
package fb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } fb_arb_state_t;

  localparam int REQ_DISP   = 0;
  localparam int REQ_EXPORT = 1;

  // A lone requester wins; on a tie the one that did not own the last frame wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_owner);
    logic owner;
    case (req)
      2'b01:   owner = 1'(REQ_DISP);
      2'b10:   owner = 1'(REQ_EXPORT);
      default: owner = ~last_owner;
    endcase
    return owner;
  endfunction

endpackage

// File: rtl/raster_addr_gen.sv
// Raster scan counters for one frame read: x/y position, linear address and
// first-pixel / end-of-line / last-pixel flags. Counters sit at 0 while run is low.
module raster_addr_gen #(
  parameter int IMG_WIDTH  = 170,
  parameter int IMG_HEIGHT = 240,
  parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  first,
  output logic                  eol,
  output logic                  last
);

  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          x_end;
  logic          y_end;

  assign x_end = (x == XW'(IMG_WIDTH - 1));
  assign y_end = (y == YW'(IMG_HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (!reset_n || !run) begin
      x <= '0;
      y <= '0;
    end else if (x_end) begin
      x <= '0;
      y <= y_end ? '0 : y + YW'(1);
    end else begin
      x <= x + XW'(1);
    end
  end

  // Address is held at 0 outside a frame read so the RAM port sees a quiet bus.
  assign addr  = run ? (ADDR_WIDTH'(y) * ADDR_WIDTH'(IMG_WIDTH) + ADDR_WIDTH'(x)) : '0;
  assign first = run && (x == '0) && (y == '0);
  assign eol   = run && x_end;
  assign last  = eol && y_end;

endmodule

// File: rtl/fb_read_arbiter.sv
// Frame-level arbiter for the camera frame buffer read port: grants whole frames,
// sequences the raster read and returns the pixel stream aligned to RAM latency.
module fb_read_arbiter
  import fb_arb_pkg::*;
#(
  parameter int RGB_WIDTH    = 24,
  parameter int IMG_WIDTH    = 170,
  parameter int IMG_HEIGHT   = 240,
  parameter int ADDR_WIDTH   = $clog2(IMG_WIDTH * IMG_HEIGHT),
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fb_valid,
  input  logic [1:0]            req,
  output logic [1:0]            gnt,
  output logic                  busy,
  output logic [1:0]            done,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic                  fb_re,
  input  logic [RGB_WIDTH-1:0]  fb_rdata,
  output logic [1:0]            o_de,
  output logic [RGB_WIDTH-1:0]  o_pixel,
  output logic                  o_sof,
  output logic                  o_eol,
  output fb_arb_state_t         dbg_state
);

  fb_arb_state_t state, state_d;
  logic          last_owner, last_owner_d;
  logic [2:0]    drain_cnt;
  logic [1:0]    owner_oh;
  logic          run;
  logic          drain_end;
  logic          r_first, r_eol, r_last;

  // Each stage carries {de[1:0], sof, eol} for one issued read.
  logic [3:0]    pipe [READ_LATENCY];

  // last_owner doubles as the current owner while a frame is granted.
  assign owner_oh  = last_owner ? 2'b10 : 2'b01;
  assign run       = (state == READ);
  assign drain_end = (state == DRAIN) && (drain_cnt == 3'(READ_LATENCY - 1));

  raster_addr_gen #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_raster (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (run),
    .addr    (fb_addr),
    .first   (r_first),
    .eol     (r_eol),
    .last    (r_last)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      drain_cnt  <= 3'd0;
    end else begin
      state      <= state_d;
      last_owner <= last_owner_d;
      drain_cnt  <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
    end
  end

  always_comb begin
    state_d      = state;
    last_owner_d = last_owner;
    case (state)
      IDLE: begin
        if (fb_valid && (req != 2'b00)) begin
          state_d      = READ;
          last_owner_d = rr_pick(req, last_owner);
        end
      end
      READ:    if (r_last) state_d = DRAIN;
      DRAIN:   if (drain_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= 4'b0000;
    end else begin
      pipe[0] <= {(run ? owner_oh : 2'b00), r_first, r_eol};
      for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign gnt       = (state != IDLE) ? owner_oh : 2'b00;
  assign busy      = (state != IDLE);
  assign done      = drain_end ? owner_oh : 2'b00;
  assign fb_re     = run;
  assign o_de      = pipe[READ_LATENCY-1][3:2];
  assign o_sof     = pipe[READ_LATENCY-1][1];
  assign o_eol     = pipe[READ_LATENCY-1][0];
  assign o_pixel   = (o_de != 2'b00) ? fb_rdata : '0;
  assign dbg_state = state;

endmodule

// File: doc/fb_read_arbiter.md
Name: fb_read_arbiter

Overview:
- Shares the single synchronous read port of the camera frame buffer between two frame-level requesters: req 0 is the display/processing path, req 1 is the UART/plotter export path.
- Grants one whole frame at a time and sequences the raster read (x/y counters, addresses, read enable).
- Returns the pixel stream with per-requester data-enable and SOF/EOL markers aligned to the RAM read latency.
- Sits between the frame buffer and the downstream readers, and replaces per-consumer address generators.

Parameters:
- RGB_WIDTH, 24, pixel word width
- IMG_WIDTH, 170, pixels per line
- IMG_HEIGHT, 240, lines per frame
- ADDR_WIDTH, $clog2(IMG_WIDTH*IMG_HEIGHT), frame buffer address width
- READ_LATENCY, 1, cycles from fb_addr/fb_re to valid fb_rdata (1..4)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- fb_valid  in  1  frame buffer holds a complete frame; arbitration is allowed only while high
- req  in  2  per-requester frame read request, level
- gnt  out  2  one-hot owner of the current frame read
- busy  out  1  a frame read or drain is in progress
- done  out  2  one-cycle pulse to the owner when its last pixel has been delivered
- fb_addr  out  ADDR_WIDTH  read address, y*IMG_WIDTH+x
- fb_re  out  1  read enable
- fb_rdata  in  RGB_WIDTH  RAM read data
- o_de  out  2  per-requester pixel valid
- o_pixel  out  RGB_WIDTH  pixel, forced to 0 when no o_de bit is set
- o_sof  out  1  qualifies pixel (0,0)
- o_eol  out  1  qualifies pixel x=IMG_WIDTH-1

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE, gnt=0, busy=0, done=0, fb_re=0, fb_addr=0, o_de=0, o_pixel=0, o_sof=0, o_eol=0, x=y=0, latency delay line cleared, last_owner=1 (so req 0 wins the first tie). Reset mid-frame aborts the read with no done pulse.
- States: IDLE, READ, DRAIN.
- IDLE:
  - If fb_valid=1 and req!=0, pick the owner: a lone requester wins; if both request, the requester != last_owner wins (round-robin).
  - At the next edge: gnt[owner]=1, busy=1, state=READ, x=y=0, last_owner=owner.
  - If fb_valid=0, requests are held off with no grant.
- READ:
  - fb_re=1 and fb_addr=y*IMG_WIDTH+x every cycle. fb_addr is combinational from the counters and is 0 outside READ.
  - x increments each cycle. At x=IMG_WIDTH-1, x wraps to 0 and y increments.
  - Exactly IMG_WIDTH*IMG_HEIGHT READ cycles.
  - At x=IMG_WIDTH-1, y=IMG_HEIGHT-1, the next state is DRAIN.
  - The frame cannot be aborted: req deasserting and fb_valid falling are both ignored while granted.
- DRAIN: lasts READ_LATENCY cycles. In its last cycle done[owner]=1. At the next edge: gnt=0, busy=0, state=IDLE.
- Re-arbitration: the earliest new grant is the edge after the return to IDLE. This leaves one idle cycle between frames, and fb_re is guaranteed low for at least that cycle.
- Output pipeline:
  - A READ_LATENCY-deep shift register carries {owner-masked de, sof(x=0,y=0), eol(x=W-1)} from READ cycles.
  - o_de[i], o_sof and o_eol are the delayed values. o_pixel = fb_rdata when o_de!=0, else 0.
  - The first pixel appears READ_LATENCY cycles after the first READ cycle.
  - The last pixel coincides with the done pulse.
- Arithmetic: the address multiply-add is done at ADDR_WIDTH bits. Maximum address is W*H-1 (40799 for the defaults, fits 16 bits). x/y counters are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT) bits.
- Invariants: gnt is at most one-hot; o_de is at most one-hot and a subset of gnt; busy equals (gnt!=0).

Decomposition:
- Package fb_arb_pkg holds:
  - the state typedef enum {IDLE, READ, DRAIN}
  - the requester index localparams REQ_DISP=0 and REQ_EXPORT=1
  - a function for the round-robin owner pick
- Sub-module raster_addr_gen covers the x/y counters, address computation, and sof/eol/last flags. Its inputs are clk, reset_n and run; its outputs are addr, first, eol and last.

Test Plan:
- Single requester (W=4, H=3, LAT=1, fb_valid=1): req=01 → gnt=01 one cycle later; fb_addr 0..11 on consecutive cycles; o_de[0] high for 12 cycles delayed 1; o_sof on pixel 0; o_eol on addresses 3, 7, 11; done[0] with pixel 11; gnt=00 the next cycle.
- Tie and round-robin: req=11 held → frames granted 0,1,0,1; exactly one idle cycle between frames; o_de[1] never high during a req-0 frame.
- fb_valid gating: req=10 with fb_valid=0 for 20 cycles → gnt=00, fb_re=0. Raise fb_valid → grant on the next edge.
- Mid-frame changes: drop req and fb_valid at address 5 → reading continues to address 11; done still pulses.
- Reset mid-frame: reset_n=0 at address 6 → all outputs 0 next cycle. A tie after reset grants req 0.
- Default geometry with LAT=3: frame of 40800 pixels; last fb_addr=40799; done 3 cycles after the last READ cycle; o_pixel equals the RAM model contents at every de.
